// File: rtl/level_pkg.sv
// level_pkg: shared constants and types for the game-flow controller.
//   NUM_BLOCKS  - number of breakable blocks (shared with color_mapper and ball logic)
//   IDX_W       - width of a block index that can also hold NUM_BLOCKS
//   lvl_state_t - game-flow state encoding
//   level_clear - true once every block has been released and none is still visible
package level_pkg;

  localparam int NUM_BLOCKS = 10;
  localparam int IDX_W      = $clog2(NUM_BLOCKS + 1);

  typedef enum logic [2:0] {
    IDLE,
    BANNER1,
    PLAY1,
    BANNER2,
    PLAY2,
    DONE
  } lvl_state_t;

  function automatic logic level_clear(input logic [IDX_W-1:0]      idx,
                                       input logic [0:NUM_BLOCKS-1] ready);
    return (idx == IDX_W'(NUM_BLOCKS)) && (ready == '0);
  endfunction

endpackage

// File: rtl/level_sequencer_if.sv
// level_sequencer_if: signals between gameplay logic and the level sequencer.
//   frame_clk   - VGA frame strobe, level signal, one rising edge per frame
//   start       - begin/restart request (pulse or held)
//   block_hit   - per-block collision report, sampled every cycle
//   level_one   - level-one banner enable
//   level_two   - level-two banner enable
//   block_ready - per-block visible/active flags
//   playing     - high in either play state
//   game_done   - high once level two is cleared
// There is no valid/ready handshake on this bus: every signal is a level that
// the receiver samples on each rising clock edge, and all sequencer outputs
// are registered.
// Modports: master = gameplay side (drives requests, watches status),
//           slave  = level_sequencer.
interface level_sequencer_if;
  import level_pkg::*;

  logic                  frame_clk;
  logic                  start;
  logic [0:NUM_BLOCKS-1] block_hit;
  logic                  level_one;
  logic                  level_two;
  logic [0:NUM_BLOCKS-1] block_ready;
  logic                  playing;
  logic                  game_done;

  modport master (
    output frame_clk, start, block_hit,
    input  level_one, level_two, block_ready, playing, game_done
  );

  modport slave (
    input  frame_clk, start, block_hit,
    output level_one, level_two, block_ready, playing, game_done
  );

endinterface

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: turns the level frame strobe into a single-cycle tick.
//   Clk       - system clock
//   Reset     - synchronous, active-high
//   frame_clk - frame strobe, synchronous to Clk
//   tick      - one-cycle pulse, high on the cycle after frame_clk is first
//               seen high; a strobe held high yields exactly one tick
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);

  logic frame_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_q <= 1'b0;
      tick    <= 1'b0;
    end else begin
      frame_q <= frame_clk;
      tick    <= frame_clk & ~frame_q;
    end
  end

endmodule

// File: rtl/level_sequencer.sv
// level_sequencer: game-flow controller feeding color_mapper.
// Walks IDLE -> BANNER1 -> PLAY1 -> BANNER2 -> PLAY2 -> DONE. Banners last
// BANNER_FRAMES frame ticks; during play one block is released every
// SPAWN_FRAMES_Ln ticks and blocks are cleared by gameplay hit reports.
//   Clk, Reset - system clock, synchronous active-high reset
//   bus        - level_sequencer_if.slave (frame strobe, start, hits in;
//                banners, block_ready, playing, game_done out)
//   state_dbg  - current FSM state, for observation only
module level_sequencer
  import level_pkg::*;
#(
  parameter int BANNER_FRAMES   = 120,
  parameter int SPAWN_FRAMES_L1 = 30,
  parameter int SPAWN_FRAMES_L2 = 15
) (
  input  logic                 Clk,
  input  logic                 Reset,
  level_sequencer_if.slave     bus,
  output lvl_state_t           state_dbg
);

  // Timers are compared by equality against "frames - 1".
  localparam logic [7:0] BANNER_LAST   = 8'(BANNER_FRAMES - 1);
  localparam logic [7:0] SPAWN_LAST_L1 = 8'(SPAWN_FRAMES_L1 - 1);
  localparam logic [7:0] SPAWN_LAST_L2 = 8'(SPAWN_FRAMES_L2 - 1);

  lvl_state_t            state, state_next;
  logic [7:0]            timer, timer_next;
  logic [IDX_W-1:0]      spawn_idx, spawn_idx_next;
  logic [0:NUM_BLOCKS-1] ready, ready_next, spawn_set;
  logic [7:0]            spawn_last;
  logic                  tick;

  frame_tick_gen u_tick (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (bus.frame_clk),
    .tick      (tick)
  );

  always_comb begin
    state_next     = state;
    timer_next     = timer;
    spawn_idx_next = spawn_idx;
    spawn_set      = '0;
    spawn_last     = (state == PLAY2) ? SPAWN_LAST_L2 : SPAWN_LAST_L1;

    case (state)
      IDLE, DONE: begin
        if (bus.start) state_next = BANNER1;
      end
      BANNER1, BANNER2: begin
        if (tick) begin
          if (timer == BANNER_LAST) state_next = (state == BANNER1) ? PLAY1 : PLAY2;
          else                      timer_next = timer + 8'd1;
        end
      end
      PLAY1, PLAY2: begin
        // Level clear needs no tick: it is judged on the registered
        // spawn index and ready vector alone.
        if (level_clear(spawn_idx, ready)) begin
          state_next = (state == PLAY1) ? BANNER2 : DONE;
        end else if (tick) begin
          if ((timer == spawn_last) && (spawn_idx < IDX_W'(NUM_BLOCKS))) begin
            spawn_set[spawn_idx] = 1'b1;
            spawn_idx_next       = spawn_idx + IDX_W'(1);
            timer_next           = '0;
          end else if (timer != 8'hFF) begin
            // Keeps counting after the last release but never wraps.
            timer_next = timer + 8'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Spawn is OR'ed in after the hit mask, so a same-cycle hit cannot
    // cancel a freshly released block.
    ready_next = (ready & ~bus.block_hit) | spawn_set;

    if (state_next != state) begin
      timer_next = '0;
      if ((state_next == BANNER1) || (state_next == BANNER2)) begin
        spawn_idx_next = '0;
        ready_next     = '0;
      end
    end
  end

  // Status outputs are decoded from state_next so they change on the same
  // edge as the state register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= IDLE;
      timer         <= '0;
      spawn_idx     <= '0;
      ready         <= '0;
      bus.level_one <= 1'b0;
      bus.level_two <= 1'b0;
      bus.playing   <= 1'b0;
      bus.game_done <= 1'b0;
    end else begin
      state         <= state_next;
      timer         <= timer_next;
      spawn_idx     <= spawn_idx_next;
      ready         <= ready_next;
      bus.level_one <= (state_next == BANNER1);
      bus.level_two <= (state_next == BANNER2);
      bus.playing   <= (state_next == PLAY1) || (state_next == PLAY2);
      bus.game_done <= (state_next == DONE);
    end
  end

  assign bus.block_ready = ready;
  assign state_dbg       = state;

endmodule

// File: tb/tb_level_sequencer.sv
// tb_level_sequencer: self-checking bench for level_sequencer.
// A behavioural game model (phase number, ticks since phase entry, count of
// released blocks) predicts every output each cycle; table vectors and a few
// hand sequences add fixed expectations for the directed corner cases.
module tb_level_sequencer;
  import level_pkg::*;

  localparam int BANNER = 4;
  localparam int SP1    = 2;
  localparam int SP2    = 1;
  localparam int EXP_W  = 4 + NUM_BLOCKS + 3;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  lvl_state_t state_dbg;

  always #5 clk = ~clk;

  level_sequencer_if bus ();

  level_sequencer #(
    .BANNER_FRAMES   (BANNER),
    .SPAWN_FRAMES_L1 (SP1),
    .SPAWN_FRAMES_L2 (SP2)
  ) dut (
    .Clk       (clk),
    .Reset     (rst),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int                checks = 0;
  int                errors = 0;
  logic [EXP_W-1:0]  exp_q[$];

  // Model: phase 0 idle, 1 banner1, 2 play1, 3 banner2, 4 play2, 5 done.
  int                    m_phase;
  int                    m_ticks;
  int                    m_spawned;
  logic [0:NUM_BLOCKS-1] m_ready;
  logic                  m_frame_prev;
  logic                  m_tick;

  task automatic expect_bits(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic void enter(input int p);
    m_phase = p;
    m_ticks = 0;
    if ((p == 1) || (p == 3)) begin
      m_spawned = 0;
      m_ready   = '0;
    end
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    logic tick_now;
    int   period;
    if (rst) begin
      m_phase = 0; m_ticks = 0; m_spawned = 0; m_ready = '0;
      m_frame_prev = 1'b0; m_tick = 1'b0;
    end else begin
      tick_now     = m_tick;
      m_tick       = bus.frame_clk && !m_frame_prev;
      m_frame_prev = bus.frame_clk;
      case (m_phase)
        0, 5: if (bus.start) enter(1);
        1, 3: begin
          if (tick_now) begin
            m_ticks++;
            if (m_ticks == BANNER) enter(m_phase + 1);
          end
        end
        2, 4: begin
          if ((m_spawned == NUM_BLOCKS) && (m_ready == '0)) begin
            enter((m_phase == 2) ? 3 : 5);
          end else begin
            m_ready &= ~bus.block_hit;
            if (tick_now) begin
              m_ticks++;
              period = (m_phase == 2) ? SP1 : SP2;
              // Block k is released on tick (k+1)*period of the level.
              if ((m_spawned < NUM_BLOCKS) && (m_ticks == (m_spawned + 1) * period)) begin
                m_ready[m_spawned] = 1'b1;
                m_spawned++;
              end
            end
          end
        end
        default: m_phase = 0;
      endcase
    end
    exp_q.push_back({(m_phase == 1), (m_phase == 3), (m_phase == 2) || (m_phase == 4),
                     (m_phase == 5), m_ready, 3'(m_phase)});
  endtask

  task automatic check_cycle();
    logic [EXP_W-1:0] want;
    logic [EXP_W-1:0] got;
    got = {bus.level_one, bus.level_two, bus.playing, bus.game_done, bus.block_ready, state_dbg};
    if (exp_q.size() == 0) begin
      expect_bits("cycle_queue_empty", 32'(exp_q.size()), 32'd1);
    end else begin
      want = exp_q.pop_front();
      expect_bits("cycle", 32'(got), 32'(want));
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic r, input logic s, input logic f,
                       input logic [0:NUM_BLOCKS-1] h);
    rst           = r;
    bus.start     = s;
    bus.frame_clk = f;
    bus.block_hit = h;
    @(posedge clk);
    model_step();
    #1;
    check_cycle();
  endtask

  task automatic run_frames(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, 1'b0, 1'b1, '0);
      repeat (9) drive(1'b0, 1'b0, 1'b0, '0);
    end
  endtask

  function automatic logic [13:0] mk(input logic l1, input logic l2, input logic p,
                                     input logic d, input logic [0:NUM_BLOCKS-1] r);
    return {l1, l2, p, d, r};
  endfunction

  function automatic logic [13:0] outs();
    return {bus.level_one, bus.level_two, bus.playing, bus.game_done, bus.block_ready};
  endfunction

  typedef struct {
    logic                  start;
    int                    frames;
    logic [0:NUM_BLOCKS-1] hit;
    logic [13:0]           exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [0:NUM_BLOCKS-1] h;
    int   f_left;
    logic f_lvl;

    vecs[0] = '{start: 1'b0, frames: 0, hit: '0, exp: mk(0, 0, 0, 0, '0)};
    vecs[1] = '{start: 1'b1, frames: 0, hit: '0, exp: mk(1, 0, 0, 0, '0)};
    vecs[2] = '{start: 1'b0, frames: 3, hit: '0, exp: mk(1, 0, 0, 0, '0)};
    vecs[3] = '{start: 1'b0, frames: 1, hit: '0, exp: mk(0, 0, 1, 0, '0)};
    vecs[4] = '{start: 1'b0, frames: 1, hit: '0, exp: mk(0, 0, 1, 0, '0)};
    vecs[5] = '{start: 1'b0, frames: 1, hit: '0, exp: mk(0, 0, 1, 0, 10'b1000000000)};
    vecs[6] = '{start: 1'b0, frames: 2, hit: '0, exp: mk(0, 0, 1, 0, 10'b1100000000)};
    vecs[7] = '{start: 1'b0, frames: 0, hit: 10'b1000000000, exp: mk(0, 0, 1, 0, 10'b0100000000)};
    vecs[8] = '{start: 1'b0, frames: 0, hit: 10'b0000010000, exp: mk(0, 0, 1, 0, 10'b0100000000)};
    vecs[9] = '{start: 1'b1, frames: 0, hit: '0, exp: mk(0, 0, 1, 0, 10'b0100000000)};

    rst = 1'b1; bus.start = 1'b0; bus.frame_clk = 1'b0; bus.block_hit = '0;
    repeat (3) drive(1'b1, 1'b0, 1'b0, '0);
    expect_bits("reset_outputs", 32'(outs()), 32'd0);
    expect_bits("reset_state", 32'(state_dbg), 32'(IDLE));

    // Reset, start, banner1 and the opening of PLAY1.
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].start || (vecs[i].hit != '0) || (vecs[i].frames == 0))
        drive(1'b0, vecs[i].start, 1'b0, vecs[i].hit);
      run_frames(vecs[i].frames);
      expect_bits($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end

    // Block 3 is released on the same edge that reports a hit on it.
    run_frames(2);
    expect_bits("spawn_block2", 32'(bus.block_ready), 32'(10'b0110000000));
    run_frames(1);
    drive(1'b0, 1'b0, 1'b1, '0);
    drive(1'b0, 1'b0, 1'b0, 10'b0001000000);
    expect_bits("hit_vs_spawn_block3", 32'(bus.block_ready[3]), 32'd1);
    repeat (8) drive(1'b0, 1'b0, 1'b0, '0);

    // Release the rest; the index saturates and the level stays in PLAY1.
    run_frames(12);
    expect_bits("all_released", 32'(bus.block_ready), 32'(10'b0111111111));
    run_frames(3);
    expect_bits("stay_play1", 32'(state_dbg), 32'(PLAY1));

    // Clear the blocks in index order.
    for (int i = 1; i < NUM_BLOCKS; i++) begin
      h = '0;
      h[i] = 1'b1;
      drive(1'b0, 1'b0, 1'b0, h);
      expect_bits($sformatf("hit_clear%0d", i), 32'(bus.block_ready[i]), 32'd0);
    end
    expect_bits("last_hit_l2_low", 32'(bus.level_two), 32'd0);
    drive(1'b0, 1'b0, 1'b0, '0);
    expect_bits("level_two_after_clear", 32'(outs()), 32'(mk(0, 1, 0, 0, '0)));

    // PLAY2 with one-tick releases, then reset with a tick and hits pending.
    run_frames(4);
    expect_bits("enter_play2", 32'(state_dbg), 32'(PLAY2));
    run_frames(6);
    expect_bits("play2_six_ready", 32'(bus.block_ready), 32'(10'b1111110000));
    drive(1'b0, 1'b0, 1'b1, '0);
    drive(1'b1, 1'b0, 1'b0, '1);
    expect_bits("midgame_reset_outputs", 32'(outs()), 32'd0);
    expect_bits("midgame_reset_state", 32'(state_dbg), 32'(IDLE));
    drive(1'b0, 1'b0, 1'b0, '0);

    // Random frame strobes (including long highs), hits, starts and resets.
    f_left = 0;
    f_lvl  = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (f_left == 0) begin
        f_lvl  = ~f_lvl;
        f_left = f_lvl ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 10));
      end
      f_left--;
      for (int b = 0; b < NUM_BLOCKS; b++) h[b] = ($urandom_range(0, 15) == 0);
      drive(($urandom_range(0, 999) == 0), ($urandom_range(0, 39) == 0), f_lvl, h);
    end

    // Full game to DONE, hitting each block as soon as it is visible.
    drive(1'b1, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b0, '0);
    for (int c = 0; (c < 3000) && (m_phase != 5); c++)
      drive(1'b0, 1'b0, (c % 10 == 0), m_ready);
    expect_bits("game_done", 32'(bus.game_done), 32'd1);
    drive(1'b0, 1'b1, 1'b0, '0);
    expect_bits("restart_from_done", 32'(outs()), 32'(mk(1, 0, 0, 0, '0)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/level_sequencer.md
# level_sequencer

Game-flow controller that drives the color mapper's level-banner and block-visibility inputs. It steps through title, level-one banner, level-one play, level-two banner, level-two play and done. During play it releases the ten blocks one at a time on a frame-based schedule and clears each block when gameplay logic reports a hit. It sits between the ball/collision logic and color_mapper, and is its only source of level_one, level_two and block_ready.

## Interface
- BANNER_FRAMES, 120: frames a level banner stays on screen (1..255)
- SPAWN_FRAMES_L1, 30: frames between block releases in level one (1..255)
- SPAWN_FRAMES_L2, 15: frames between block releases in level two (1..255)
- Clk  in  1  system clock; the only clock
- Reset  in  1  synchronous, active-high reset
- frame_clk  in  1  VGA frame strobe (level signal, one rising edge per frame), synchronous to Clk
- start  in  1  single-cycle or held request to begin or restart the game
- block_hit [0:NUM_BLOCKS-1]  in  1 each  collision report per block, sampled every cycle
- level_one  out  1  level-one banner enable to color_mapper
- level_two  out  1  level-two banner enable to color_mapper
- block_ready [0:NUM_BLOCKS-1]  out  1 each  block visible/active to color_mapper
- playing  out  1  high in PLAY1 or PLAY2
- game_done  out  1  high in DONE

## Operation
- Frame tick: internal single-cycle pulse, asserted on the cycle after a 0->1 transition of registered frame_clk. Only ticks advance the timers.
- States:
  - IDLE -> BANNER1 on start.
  - BANNER1 -> PLAY1 after BANNER_FRAMES ticks.
  - PLAY1 -> BANNER2 when the level is clear.
  - BANNER2 -> PLAY2 after BANNER_FRAMES ticks.
  - PLAY2 -> DONE when the level is clear.
  - DONE -> BANNER1 on start.
- start is ignored in every state except IDLE and DONE.
- Entering any state clears the frame timer. Entering BANNER1 or BANNER2 also clears spawn_idx and all block_ready bits.
- level_one = (state==BANNER1); level_two = (state==BANNER2).
- Spawn in PLAYn:
  - On each tick the timer increments.
  - When the timer equals SPAWN_FRAMES_Ln-1 and spawn_idx < NUM_BLOCKS: set block_ready[spawn_idx], increment spawn_idx, zero the timer.
  - The first block appears SPAWN_FRAMES_Ln ticks after entering PLAYn.
- Hit: block_ready_next[i] = (block_ready[i] & ~block_hit[i]) | spawn_set[i].
  - A hit on a block that is not ready is ignored.
  - If a hit and a spawn target the same index in the same cycle, the spawn wins and the block ends ready.
  - Multiple hits in one cycle clear all indicated blocks.
- Level clear: spawn_idx == NUM_BLOCKS and all block_ready == 0, evaluated on registered state. The transition occurs on the next edge and does not require a tick.
- Widths:
  - frame timer is 8 bits unsigned, compared by equality, and never exceeds 255.
  - spawn_idx is $clog2(NUM_BLOCKS+1) bits and saturates at NUM_BLOCKS.

## Timing
- All outputs are registered, with no combinational path from input to output.
- Reset values: state IDLE, all outputs 0, timers 0, spawn_idx 0, frame_clk edge register 0.
- Reset asserted mid-game returns to IDLE on the next edge, regardless of pending ticks or hits.
- start -> BANNER1: level_one rises 1 cycle after start is sampled.
- Tick latency is 1 cycle after the frame_clk rise. A spawn appears on block_ready 1 cycle after the tick cycle.
- block_hit[i] -> block_ready[i] falls 1 cycle later.
- Last hit clearing a level:
  - block_ready all 0 at edge N+1.
  - state leaves PLAYn at edge N+2.
  - level_two or game_done is high from edge N+2.
- A frame_clk held high produces exactly one tick.

## Structure
- Package level_pkg:
  - localparam NUM_BLOCKS = 10 (shared with color_mapper and ball logic).
  - typedef enum logic [2:0] lvl_state_t {IDLE, BANNER1, PLAY1, BANNER2, PLAY2, DONE}.
- Sub-module frame_tick_gen: registers frame_clk and emits a single-cycle tick. It has Clk and synchronous Reset.
- Top: one state register, one frame timer, spawn_idx, and the block_ready vector. Next-state and next-ready logic sit in always_comb.

## Test plan
Benches run with BANNER_FRAMES=4, SPAWN_FRAMES_L1=2, SPAWN_FRAMES_L2=1, and frame_clk pulsed every 10 cycles.
- Reset held 3 cycles, then start=1 for 1 cycle -> level_one=1 the next cycle; level_one falls and playing=1 one cycle after the 4th tick.
- PLAY1 with no hits -> block_ready[0] sets after the 2nd tick and block_ready[k] after tick 2(k+1); spawn_idx stops at 10 with all 10 bits high; state stays PLAY1.
- Hit each ready block in index order -> each bit clears 1 cycle after its hit; after the last hit, level_two=1 two cycles later.
- block_hit[3]=1 in the same cycle that block 3 spawns -> block_ready[3]=1 afterwards. block_hit[5] before block 5 spawns -> no effect.
- Reset asserted during PLAY2 with 6 blocks ready -> next cycle all outputs 0 and state IDLE. start while in PLAY1 -> ignored.
- Full game through PLAY2 (1-tick spawns) with all blocks hit -> game_done=1. start -> level_one=1 and block_ready all 0.
